// File: rtl/vigenere_decryptor_if.sv
// Byte-stream handshake bundle for the Vigenere decryptor: one ready/valid
// input channel carrying key or ciphertext bytes, one ready/valid output
// channel carrying plaintext bytes.
interface vigenere_decryptor_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;

  // Byte source / plaintext sink side
  modport master (
    output in_valid,
    output in_char,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_char
  );

  // Decryptor side
  modport slave (
    input  in_valid,
    input  in_char,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_char
  );
endinterface

// File: rtl/vigenere_decryptor.sv
// Four-letter-key Vigenere decryptor. Enter pulses walk the mode through
// START -> KEY0..KEY3 (key bytes captured) -> DECR (ciphertext decrypted,
// one registered plaintext byte per accepted input) -> START.
module vigenere_decryptor #(
  parameter logic [7:0] IDLE_CHAR = 8'd32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enter,
  vigenere_decryptor_if.slave        bus,
  output logic [2:0]                 state,
  output logic [1:0]                 key_idx
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_KEY0  = 3'd1,
    S_KEY1  = 3'd2,
    S_KEY2  = 3'd3,
    S_KEY3  = 3'd4,
    S_DECR  = 3'd5
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] key [4];
  logic [1:0] key_idx_q;
  logic       out_valid_q;
  logic [7:0] out_char_q;

  logic       accept;
  logic       entering_decr;
  logic [7:0] key_byte;
  logic [4:0] shift;
  logic       c_upper;
  logic       c_lower;
  logic       c_alpha;
  logic [4:0] c_off;
  logic [5:0] diff;
  logic [7:0] plain;

  // Mode register; the only place the state advances
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_START;
    else        state_q <= state_d;
  end

  // Next mode: each enter pulse steps one mode forward, illegal codes recover to START
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: if (enter) state_d = S_KEY0;
      S_KEY0:  if (enter) state_d = S_KEY1;
      S_KEY1:  if (enter) state_d = S_KEY2;
      S_KEY2:  if (enter) state_d = S_KEY3;
      S_KEY3:  if (enter) state_d = S_DECR;
      S_DECR:  if (enter) state_d = S_START;
      default: state_d = S_START;
    endcase
  end

  assign state         = state_q;
  assign key_idx       = key_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;

  // In DECR the input stalls only while an undrained plaintext byte is waiting
  assign bus.in_ready  = (state_q == S_DECR) ? (!out_valid_q || bus.out_ready) : 1'b1;
  assign accept        = bus.in_valid && bus.in_ready;
  assign entering_decr = (state_d == S_DECR) && (state_q != S_DECR);

  // Key slots: wiped whenever the mode is (or is becoming) START, else capture in KEYn
  always_ff @(posedge clk) begin
    if (!reset || state_d == S_START) begin
      for (int i = 0; i < 4; i++) key[i] <= 8'd0;
    end else if (accept) begin
      case (state_q)
        S_KEY0:  key[0] <= bus.in_char;
        S_KEY1:  key[1] <= bus.in_char;
        S_KEY2:  key[2] <= bus.in_char;
        S_KEY3:  key[3] <= bus.in_char;
        default: ;
      endcase
    end
  end

  // Shift from the active key letter, then modular subtraction within the letter's case range
  always_comb begin
    key_byte = key[key_idx_q];
    shift    = 5'd0;
    if (key_byte >= 8'd65 && key_byte <= 8'd90)       shift = 5'(key_byte - 8'd65);
    else if (key_byte >= 8'd97 && key_byte <= 8'd122) shift = 5'(key_byte - 8'd97);

    c_upper = (bus.in_char >= 8'd65) && (bus.in_char <= 8'd90);
    c_lower = (bus.in_char >= 8'd97) && (bus.in_char <= 8'd122);
    c_alpha = c_upper || c_lower;
    c_off   = 5'd0;
    if (c_upper)      c_off = 5'(bus.in_char - 8'd65);
    else if (c_lower) c_off = 5'(bus.in_char - 8'd97);

    diff = 6'd26 + {1'b0, c_off} - {1'b0, shift};
    if (diff >= 6'd26) diff = diff - 6'd26;

    plain = bus.in_char;
    if (c_upper)      plain = 8'd65 + {2'b00, diff};
    else if (c_lower) plain = 8'd97 + {2'b00, diff};
  end

  // Key pointer: restarts at slot 0 on entry to DECR, steps only on letters
  always_ff @(posedge clk) begin
    if (!reset)                                    key_idx_q <= 2'd0;
    else if (entering_decr)                        key_idx_q <= 2'd0;
    else if (accept && state_q == S_DECR && c_alpha) key_idx_q <= key_idx_q + 2'd1;
  end

  // Output register: load on a DECR accept, hold while stalled, clear once drained
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_char_q  <= IDLE_CHAR;
    end else if (accept && state_q == S_DECR) begin
      out_valid_q <= 1'b1;
      out_char_q  <= plain;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
